alu_long_seq: RTL
=================

ALU_LONG_SEQ -- requirements
Module: alu_long_seq

Interface
REQ-001 SHALL have parameter BITS, default 16, meaning the ALU word width; the long operand width is 2*BITS.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous and active-low.
REQ-004 SHALL have port start, input, 1, operation request; sampled only in IDLE.
REQ-005 SHALL have port size, input, 1, operand size: 0 = word, 1 = long.
REQ-006 SHALL have port op, input, 3, ALU operation code (ADD = 0).
REQ-007 SHALL have port a, input, 2*BITS, destination/first operand.
REQ-008 SHALL have port b, input, 2*BITS, source/second operand.
REQ-009 SHALL have port x_in, input, 1, extend/carry-in for the low pass.
REQ-010 SHALL have port busy, output, 1, high while state is not IDLE.
REQ-011 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 SHALL have port result, output, 2*BITS, registered result.
REQ-013 SHALL have ports c, z, v, n, output, 1 each, registered flags of the completed operation.

Function
REQ-014 SHALL implement states IDLE, LO, HI, DONE.
REQ-015 In IDLE, with start=1 at an edge, SHALL latch a, b, op, size and x_in and go to LO; start in any other state SHALL be ignored.
REQ-016 In LO, SHALL drive the ALU with a[BITS-1:0], b[BITS-1:0], latched op and x = latched x_in; at the edge it SHALL latch o into result[BITS-1:0] and the low carry and zero.
REQ-017 From LO, SHALL go to HI if size=1, else to DONE.
REQ-018 In HI, SHALL drive the ALU with the upper halves and x = the carry latched in LO; at the edge it SHALL latch o into result[2*BITS-1:BITS] and go to DONE.
REQ-019 In DONE, done SHALL be 1 for exactly one cycle, then the block SHALL return to IDLE.
REQ-020 Word latency: done SHALL be high in the second cycle after the start-accepting edge; long latency: the third cycle.
REQ-021 Word ops: result[2*BITS-1:BITS] SHALL equal the latched a[2*BITS-1:BITS], and c, v, n SHALL come from the LO pass.
REQ-022 Long ops: c, v, n SHALL come from the HI pass.
REQ-023 z SHALL be 1 only when every pass executed produced zero.
REQ-024 result and flags SHALL hold their values from DONE until the next accepted start completes its first pass.

Reset
REQ-025 rst_n=0 at an edge SHALL force IDLE, with busy=0, done=0, result=0 and c=z=v=n=0.
REQ-026 Reset asserted during LO, HI or DONE SHALL abort the operation; no done pulse SHALL follow.

Configuration
REQ-027 With macro ALU_LONG_SEQ_LONG_EN defined, SHALL support size=1 as specified.
REQ-028 Without ALU_LONG_SEQ_LONG_EN, SHALL omit state HI, ignore size and treat every operation as word.

Structure
REQ-029 ALU op-code constants (ADD = 3'd0 and the others) and the state encoding SHALL live in shared package alu_pkg.
REQ-030 SHALL instantiate the existing Alu module with parameter BITS as its single sub-module; it SHALL add no arithmetic of its own beyond flag combining.

Verification
REQ-031 Word ADD, a=0000_010F, b=0000_010F, x_in=0 -> result 0000_021E, czvn=0000, done in cycle 2.
REQ-032 Long ADD, a=0000_FFFF, b=0000_0001 -> result 0001_0000, czvn=0000, done in cycle 3 (carry chained into HI).
REQ-033 Long ADD, a=FFFF_FFFF, b=0000_0001 -> result 0000_0000, c=1, z=1, v=0, n=0.
REQ-034 Long ADD, a=7FFF_FFFF, b=0000_0001 -> result 8000_0000, v=1, n=1, c=0, z=0.
REQ-035 Word ADD, a=1234_FFFF, b=0000_0001 -> result 1234_0000, c=1, z=1; a second start pulsed while busy is ignored (exactly one done pulse).
REQ-036 Long op with rst_n=0 during HI -> next cycle IDLE, result=0, flags=0, and no done pulse.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU and the long-operand sequencer:
//   - ALU op-code constants (3-bit op field, ADD = 0)
//   - FSM state encoding for alu_long_seq
// Configuration macro: ALU_LONG_SEQ_LONG_EN adds the HI state used by
// two-pass (long) operations; without it the sequencer is word-only.
// ---------------------------------------------------------------------------
package alu_pkg;

   // ALU operation codes
   localparam logic [2:0] OP_ADD   = 3'd0;  // o = a + b + x
   localparam logic [2:0] OP_SUB   = 3'd1;  // o = a - b - x, c = borrow
   localparam logic [2:0] OP_AND   = 3'd2;
   localparam logic [2:0] OP_OR    = 3'd3;
   localparam logic [2:0] OP_XOR   = 3'd4;
   localparam logic [2:0] OP_PASSB = 3'd5;  // o = b
   localparam logic [2:0] OP_PASSA = 3'd6;  // o = a
   localparam logic [2:0] OP_NOTA  = 3'd7;  // o = ~a

   // Sequencer states; HI only exists when long operands are enabled
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LO   = 2'd1,
`ifdef ALU_LONG_SEQ_LONG_EN
      S_DONE = 2'd2,
      S_HI   = 2'd3
`else
      S_DONE = 2'd2
`endif
   } state_t;

endpackage

// File: rtl/alu_long_seq_alu.sv
// ---------------------------------------------------------------------------
// Alu
// Purely combinational BITS-wide ALU with extend/carry input.
// Ports:
//   a, b  : operands (BITS)
//   op    : operation code (see alu_pkg)
//   x     : extend / carry-in (borrow-in for SUB)
//   o     : result (BITS)
//   c,z,v,n : carry/borrow, zero, signed overflow, negative
// Logic ops and pass ops report c = v = 0.
// ---------------------------------------------------------------------------
module Alu
   import alu_pkg::*;
#(
   parameter int BITS = 16
) (
   input  logic [BITS-1:0] a,
   input  logic [BITS-1:0] b,
   input  logic [2:0]      op,
   input  logic            x,
   output logic [BITS-1:0] o,
   output logic            c,
   output logic            z,
   output logic            v,
   output logic            n
);

   logic [BITS:0] w_sum;

   // Operation select. The sum/difference is computed one bit wider so the
   // top bit is the carry out for ADD and the borrow out for SUB.
   always_comb begin
      w_sum = '0;
      o     = '0;
      c     = 1'b0;
      v     = 1'b0;
      case (op)
         OP_ADD: begin
            w_sum = {1'b0, a} + {1'b0, b} + {{BITS{1'b0}}, x};
            o     = w_sum[BITS-1:0];
            c     = w_sum[BITS];
            v     = (a[BITS-1] == b[BITS-1]) && (o[BITS-1] != a[BITS-1]);
         end
         OP_SUB: begin
            w_sum = {1'b0, a} - {1'b0, b} - {{BITS{1'b0}}, x};
            o     = w_sum[BITS-1:0];
            c     = w_sum[BITS];
            v     = (a[BITS-1] != b[BITS-1]) && (o[BITS-1] != a[BITS-1]);
         end
         OP_AND:   o = a & b;
         OP_OR:    o = a | b;
         OP_XOR:   o = a ^ b;
         OP_PASSB: o = b;
         OP_PASSA: o = a;
         default:  o = ~a;
      endcase
   end

   // Zero and negative simply describe the selected result
   assign z = (o == '0);
   assign n = o[BITS-1];

endmodule

// File: rtl/alu_long_seq.sv
// ---------------------------------------------------------------------------
// alu_long_seq
// Runs word (BITS) or long (2*BITS) operations through a single BITS-wide
// Alu, one half per clock: LO pass on the low halves, then (long only) HI
// pass on the high halves with the LO carry chained in.
// Configuration macro: ALU_LONG_SEQ_LONG_EN enables long operations; when it
// is undefined the size input is ignored and every operation is a word op.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   start            : operation request, only honoured in IDLE
//   size             : 0 = word, 1 = long
//   op               : ALU op code (alu_pkg)
//   a, b             : operands (2*BITS), x_in : carry-in for the LO pass
//   busy, done       : not-IDLE flag, one-cycle completion pulse
//   result, c,z,v,n  : registered result and flags of the last operation
// ---------------------------------------------------------------------------
module alu_long_seq
   import alu_pkg::*;
#(
   parameter int BITS = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              size,
   input  logic [2:0]        op,
   input  logic [2*BITS-1:0] a,
   input  logic [2*BITS-1:0] b,
   input  logic              x_in,
   output logic              busy,
   output logic              done,
   output logic [2*BITS-1:0] result,
   output logic              c,
   output logic              z,
   output logic              v,
   output logic              n
);

   state_t            r_state;
   logic [2*BITS-1:0] r_a;
   logic [BITS-1:0]   r_bLo;
   logic [2:0]        r_op;
   logic              r_x;
`ifdef ALU_LONG_SEQ_LONG_EN
   logic [BITS-1:0]   r_bHi;
   logic              r_size;
`else
   logic [BITS:0]     w_unusedIn;
`endif

   logic [BITS-1:0]   w_aluA;
   logic [BITS-1:0]   w_aluB;
   logic              w_aluX;
   logic [BITS-1:0]   w_aluO;
   logic              w_aluC;
   logic              w_aluZ;
   logic              w_aluV;
   logic              w_aluN;

`ifndef ALU_LONG_SEQ_LONG_EN
   // Word-only build never looks at size or the upper half of b
   assign w_unusedIn = {size, b[2*BITS-1:BITS]};
`endif

   // Feed the ALU with the half being processed. In HI the carry-in is the
   // c register, which at that point still holds the carry of the LO pass.
   always_comb begin
      w_aluA = r_a[BITS-1:0];
      w_aluB = r_bLo;
      w_aluX = r_x;
`ifdef ALU_LONG_SEQ_LONG_EN
      if (r_state == S_HI) begin
         w_aluA = r_a[2*BITS-1:BITS];
         w_aluB = r_bHi;
         w_aluX = c;
      end
`endif
   end

   Alu #(
      .BITS (BITS)
   ) u_alu (
      .a  (w_aluA),
      .b  (w_aluB),
      .op (r_op),
      .x  (w_aluX),
      .o  (w_aluO),
      .c  (w_aluC),
      .z  (w_aluZ),
      .v  (w_aluV),
      .n  (w_aluN)
   );

   // Sequencer with registered outputs. Result and flags are left alone on
   // accept so the previous answer stays visible until the new LO pass ends.
   // The LO pass also writes the upper result half with the latched a, which
   // is the final value for word ops and is overwritten by HI for long ops.
   // z from LO is ANDed with the HI zero so z means "whole result is zero".
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         result  <= '0;
         c       <= 1'b0;
         z       <= 1'b0;
         v       <= 1'b0;
         n       <= 1'b0;
         r_a     <= '0;
         r_bLo   <= '0;
         r_op    <= OP_ADD;
         r_x     <= 1'b0;
`ifdef ALU_LONG_SEQ_LONG_EN
         r_bHi   <= '0;
         r_size  <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_a     <= a;
                  r_bLo   <= b[BITS-1:0];
                  r_op    <= op;
                  r_x     <= x_in;
`ifdef ALU_LONG_SEQ_LONG_EN
                  r_bHi   <= b[2*BITS-1:BITS];
                  r_size  <= size;
`endif
                  busy    <= 1'b1;
                  r_state <= S_LO;
               end
            end
            S_LO: begin
               result <= {r_a[2*BITS-1:BITS], w_aluO};
               c      <= w_aluC;
               z      <= w_aluZ;
               v      <= w_aluV;
               n      <= w_aluN;
`ifdef ALU_LONG_SEQ_LONG_EN
               if (r_size) begin
                  r_state <= S_HI;
               end else begin
                  r_state <= S_DONE;
                  done    <= 1'b1;
               end
`else
               r_state <= S_DONE;
               done    <= 1'b1;
`endif
            end
`ifdef ALU_LONG_SEQ_LONG_EN
            S_HI: begin
               result[2*BITS-1:BITS] <= w_aluO;
               c       <= w_aluC;
               z       <= z & w_aluZ;
               v       <= w_aluV;
               n       <= w_aluN;
               r_state <= S_DONE;
               done    <= 1'b1;
            end
`endif
            S_DONE: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
